// File: rtl/water_level_pkg.sv
// Shared level codes and the tank image generator for the water-level matrix scanner.
package water_level_pkg;

    localparam int LEVEL_CRITICAL = 0;
    localparam int LEVEL_LOW      = 1;
    localparam int LEVEL_MID      = 2;
    localparam int LEVEL_HIGH     = 3;

    // Widest column the image function can describe; callers slice [ROWS-1:0].
    localparam int MAX_ROWS = 64;

    // Lit pattern (1 = lit, bit index = row, row 0 on top) for one matrix column.
    function automatic logic [MAX_ROWS-1:0] image_column(input int col, input int fill,
                                                         input int rows, input int cols);
        logic [MAX_ROWS-1:0] img;
        img = '0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            if (r < rows) begin
                if (r == rows - 1)
                    img[r] = 1'b1;
                else if (col == 0 || col == cols - 1)
                    img[r] = 1'b1;
                else if (r >= 1 && r >= rows - 1 - fill)
                    img[r] = 1'b1;
            end
        end
        return img;
    endfunction

endpackage

// File: rtl/water_level_filter.sv
// Debounce of the sampled level code: a new level is shown only after STABLE_CNT equal samples.
module water_level_filter
    import water_level_pkg::*;
#(
    parameter int LEVEL_W    = 2,
    parameter int STABLE_CNT = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               level_valid,
    output logic [LEVEL_W-1:0] level_shown
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    logic [LEVEL_W-1:0] cand;
    logic [LEVEL_W-1:0] cand_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (level == cand) begin
            if (cnt != CNT_W'(STABLE_CNT))
                cnt_nxt = cnt + 1'b1;
        end else begin
            cand_nxt = level;
            cnt_nxt  = CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand        <= '0;
            cnt         <= '0;
            level_shown <= '0;
        end else if (level_valid) begin
            cand <= cand_nxt;
            cnt  <= cnt_nxt;
            if (cnt_nxt == CNT_W'(STABLE_CNT))
                level_shown <= cand_nxt;
        end
    end

endmodule

// File: rtl/water_level_matrix_scanner.sv
// Column-multiplexed LED matrix driver showing a debounced tank fill level.
// Optional critical-level blinking is enabled with `define WATER_LEVEL_MATRIX_BLINK_EN.
module water_level_matrix_scanner
    import water_level_pkg::*;
#(
    parameter int ROWS         = 7,
    parameter int COLS         = 5,
    parameter int LEVEL_W      = 2,
    parameter int FILL_STEP    = 2,
    parameter int STABLE_CNT   = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               level_valid,
    output logic [COLS-1:0]    col_en,
    output logic [ROWS-1:0]    row_n,
    output logic               frame_start,
    output logic [LEVEL_W-1:0] level_shown
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(COLS);

    logic [PW-1:0]       presc;
    logic [CW-1:0]       col_idx;
    logic [CW-1:0]       col_nxt;
    logic                tc;
    logic                wrap;
    int                  fill;
    logic [MAX_ROWS-1:0] img_full;
    logic [ROWS-1:0]     img_nxt;
    logic [ROWS-1:0]     row_nxt;
    logic                unused_img_hi;

    water_level_filter #(
        .LEVEL_W    (LEVEL_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_filter (
        .clock       (clock),
        .reset       (reset),
        .level       (level),
        .level_valid (level_valid),
        .level_shown (level_shown)
    );

    assign tc      = (presc == PW'(SCAN_DIV - 1));
    assign wrap    = tc && (col_idx == CW'(COLS - 1));
    assign col_nxt = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + 1'b1;

    // Computed in int so a large level * FILL_STEP can never wrap before clamping.
    always_comb begin
        fill = int'(level_shown) * FILL_STEP;
        if (fill > ROWS - 2)
            fill = ROWS - 2;
    end

    assign img_full      = image_column(int'(col_nxt), fill, ROWS, COLS);
    assign img_nxt       = img_full[ROWS-1:0];
    assign unused_img_hi = ^img_full[MAX_ROWS-1:ROWS];

`ifdef WATER_LEVEL_MATRIX_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_nxt;
    logic          blink;
    logic          blink_nxt;

    // Counting on the wrap edge itself lets the toggle blank column 0 of the new frame.
    always_comb begin
        frame_cnt_nxt = frame_cnt;
        blink_nxt     = blink;
        if (level_shown != '0) begin
            frame_cnt_nxt = '0;
            blink_nxt     = 1'b0;
        end else if (wrap) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_nxt = '0;
                blink_nxt     = ~blink;
            end else begin
                frame_cnt_nxt = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            blink     <= blink_nxt;
        end
    end

    assign row_nxt = (level_shown == '0 && blink_nxt) ? '1 : ~img_nxt;
`else
    assign row_nxt = ~img_nxt;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            col_idx     <= '0;
            col_en      <= COLS'(1);
            row_n       <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (tc) begin
                presc   <= '0;
                col_idx <= col_nxt;
                col_en  <= {col_en[COLS-2:0], col_en[COLS-1]};
                row_n   <= row_nxt;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_water_level_matrix_scanner.sv
// Directed, table-driven bench for water_level_matrix_scanner (SCAN_DIV reduced to 4).
module tb_water_level_matrix_scanner;

    localparam int ROWS = 7;
    localparam int COLS = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      level = 2'd0;
    logic            level_valid = 1'b0;
    logic [COLS-1:0] col_en;
    logic [ROWS-1:0] row_n;
    logic            frame_start;
    logic [1:0]      level_shown;

    int checks   = 0;
    int failures = 0;

    water_level_matrix_scanner #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .LEVEL_W      (2),
        .FILL_STEP    (2),
        .STABLE_CNT   (3),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .level       (level),
        .level_valid (level_valid),
        .col_en      (col_en),
        .row_n       (row_n),
        .frame_start (frame_start),
        .level_shown (level_shown)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]      lvl;
        int              strobes;
        logic [1:0]      exp_shown;
        logic [ROWS-1:0] exp_interior;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [1:0] lv);
        level       = lv;
        level_valid = 1'b1;
        @(posedge clock);
        #1;
        level_valid = 1'b0;
    endtask

    // Steps until col_en changes to tgt; a missed target counts as a failure.
    task automatic next_col(input logic [COLS-1:0] tgt);
        logic [COLS-1:0] prev;
        bit found;
        prev  = col_en;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clock);
            #1;
            if (col_en != prev && col_en == tgt) found = 1'b1;
            prev = col_en;
        end
        check("col_timeout", 32'(found), 32'd1);
    endtask

    task automatic first_frame_start(input string name);
        int first;
        first = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clock);
            #1;
            if (frame_start && first < 0) first = cyc;
        end
        check(name, 32'(first), 32'd20);
    endtask

    initial begin
        vecs[0] = '{lvl: 2'd2, strobes: 3, exp_shown: 2'd2, exp_interior: 7'b0000011};
        vecs[1] = '{lvl: 2'd3, strobes: 2, exp_shown: 2'd2, exp_interior: 7'b0000011};
        vecs[2] = '{lvl: 2'd1, strobes: 1, exp_shown: 2'd2, exp_interior: 7'b0000011};
        vecs[3] = '{lvl: 2'd1, strobes: 2, exp_shown: 2'd1, exp_interior: 7'b0001111};
        vecs[4] = '{lvl: 2'd3, strobes: 3, exp_shown: 2'd3, exp_interior: 7'b0000001};
        vecs[5] = '{lvl: 2'd0, strobes: 1, exp_shown: 2'd3, exp_interior: 7'b0000001};

        #12;
        check("rst_col_en", 32'(col_en), 32'h01);
        check("rst_row_n", 32'(row_n), 32'h7f);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_level_shown", 32'(level_shown), 32'd0);

        @(negedge clock);
        reset = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clock);
            #1;
            if (cyc == 3) begin
                check("pre_adv_col_en", 32'(col_en), 32'h01);
                check("pre_adv_row_n", 32'(row_n), 32'h7f);
            end
        end
        check("adv1_col_en", 32'(col_en), 32'h02);
        check("adv1_row_n_lvl0", 32'(row_n), 32'(7'b0111111));
        // Already 4 cycles in; remaining 26 cycles see the first pulse at overall cycle 20.
        begin
            int first;
            first = -1;
            for (int cyc = 5; cyc <= 30; cyc++) begin
                @(posedge clock);
                #1;
                if (frame_start && first < 0) first = cyc;
            end
            check("first_frame_start", 32'(first), 32'd20);
        end

        for (int v = 0; v < 6; v++) begin
            for (int s = 0; s < vecs[v].strobes; s++) strobe(vecs[v].lvl);
            check($sformatf("vec%0d_shown", v), 32'(level_shown), 32'(vecs[v].exp_shown));
            next_col(5'b00010);
            check($sformatf("vec%0d_interior", v), 32'(row_n), 32'(vecs[v].exp_interior));
            next_col(5'b10000);
            check($sformatf("vec%0d_wall", v), 32'(row_n), 32'd0);
        end

        // Level update coinciding with a column advance: the new column still uses the old level.
        next_col(5'b00010);
        strobe(2'd1);
        strobe(2'd1);
        @(posedge clock);
        #1;
        strobe(2'd1);
        check("same_edge_col_en", 32'(col_en), 32'h04);
        check("same_edge_row_n_old", 32'(row_n), 32'(7'b0000001));
        check("same_edge_shown", 32'(level_shown), 32'd1);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        check("after_edge_col_en", 32'(col_en), 32'h08);
        check("after_edge_row_n_new", 32'(row_n), 32'(7'b0001111));

        next_col(5'b01000);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_col_en", 32'(col_en), 32'h01);
        check("midrst_row_n", 32'(row_n), 32'h7f);
        check("midrst_shown", 32'(level_shown), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        first_frame_start("midrst_first_frame_start");

`ifdef WATER_LEVEL_MATRIX_BLINK_EN
        level = 2'd0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int cyc = 1; cyc <= 124; cyc++) begin
            @(posedge clock);
            #1;
            level_valid = 1'b0;
            case (cyc)
                24:  check("blink_f1_img", 32'(row_n), 32'(7'b0111111));
                40:  check("blink_f2_col0_blank", 32'(row_n), 32'h7f);
                44:  check("blink_f2_blank", 32'(row_n), 32'h7f);
                64:  check("blink_f3_blank", 32'(row_n), 32'h7f);
                84:  check("blink_f4_img", 32'(row_n), 32'(7'b0111111));
                120: check("blink_f6_blank", 32'(row_n), 32'h7f);
                124: check("blink_lvl1_img", 32'(row_n), 32'(7'b0001111));
                default: ;
            endcase
            if (cyc >= 120 && cyc <= 122) begin
                level       = 2'd1;
                level_valid = 1'b1;
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
